// File: rtl/piso_shift_tx.sv
`default_nettype none
// ============================================================================
// Module      : piso_shift_tx
// Description : Parallel-in serial-out transmitter. Captures an N-bit word over
//               a valid/ready handshake and shifts it out MSB-first, one bit per
//               shift_en strobe, ending with a one-cycle done pulse.
//               Define PISO_PARITY_EN to append an even-parity bit per word.
// Revision    : 1.0 - initial release
// ============================================================================
module piso_shift_tx #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] I,
    input  logic         load_valid,
    output logic         load_ready,
    input  logic         shift_en,
    output logic         sout,
    output logic         sout_valid,
    output logic         done
);

    localparam int c_CNT_W = $clog2(N + 1);

`ifdef PISO_PARITY_EN
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(N);
`else
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(N - 1);
`endif

    localparam logic [0:0] c_IDLE  = 1'b0;
    localparam logic [0:0] c_SHIFT = 1'b1;

    logic [0:0]         r_state;
    logic [N-1:0]       r_sreg;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_done;

    logic w_load;
    logic w_shift;
    logic w_last;

    assign w_load  = (r_state == c_IDLE) && load_valid;
    assign w_shift = (r_state == c_SHIFT) && shift_en;
    assign w_last  = (r_cnt == c_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
            r_sreg  <= '0;
            r_cnt   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= w_shift && w_last;
            if (w_load) begin
                r_state <= c_SHIFT;
                r_sreg  <= I;
                r_cnt   <= '0;
            end else if (w_shift) begin
                if (w_last) begin
                    r_state <= c_IDLE;
                end else begin
                    r_sreg <= {r_sreg[N-2:0], 1'b0};
                    r_cnt  <= r_cnt + c_CNT_W'(1);
                end
            end
        end
    end

`ifdef PISO_PARITY_EN
    logic r_par;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_par <= 1'b0;
        end else if (w_load) begin
            r_par <= ^I;
        end
    end
`endif

    always_comb begin
        load_ready = (r_state == c_IDLE);
        sout_valid = (r_state == c_SHIFT);
        sout       = 1'b0;
        if (r_state == c_SHIFT) begin
`ifdef PISO_PARITY_EN
            // Once all N data bits are consumed the counter sits on the parity slot.
            sout = (r_cnt == c_LAST) ? r_par : r_sreg[N-1];
`else
            sout = r_sreg[N-1];
`endif
        end
    end

    assign done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_piso_shift_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_piso_shift_tx
// Description : Self-checking bench for piso_shift_tx with a serial-bit
//               scoreboard; honours PISO_PARITY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_piso_shift_tx;

    localparam int N = 4;
`ifdef PISO_PARITY_EN
    localparam int c_BITS = N + 1;
`else
    localparam int c_BITS = N;
`endif

    logic         clk        = 1'b0;
    logic         rst_n      = 1'b1;
    logic [N-1:0] I          = '0;
    logic         load_valid = 1'b0;
    logic         shift_en   = 1'b0;
    logic         load_ready;
    logic         sout;
    logic         sout_valid;
    logic         done;

    int vectors     = 0;
    int miscompares = 0;
    int cycle       = 0;
    int done_cnt    = 0;
    int last_done   = 0;
    int prev_done   = 0;
    logic exp_q[$];
    logic exp_b;

    piso_shift_tx #(.N(N)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .I          (I),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .shift_en   (shift_en),
        .sout       (sout),
        .sout_valid (sout_valid),
        .done       (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cycle++;
        #1;
        if (done) begin
            prev_done = last_done;
            last_done = cycle;
            done_cnt++;
        end
    end

    // A bit is consumed on the edge following a negedge where both are high.
    always @(negedge clk) begin
        if (rst_n && sout_valid && shift_en) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL stream_extra: sout=%b but no bit expected", sout);
            end else begin
                exp_b = exp_q.pop_front();
                if (sout !== exp_b) begin
                    miscompares++;
                    $display("FAIL stream_bit: sout=%b expected %b", sout, exp_b);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [N-1:0] w);
        for (int i = N - 1; i >= 0; i--) exp_q.push_back(w[i]);
`ifdef PISO_PARITY_EN
        exp_q.push_back(^w);
`endif
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        vectors++; if (load_ready !== 1'b1) begin miscompares++; $display("FAIL reset_load_ready: got %b want 1", load_ready); end
        vectors++; if (sout !== 1'b0) begin miscompares++; $display("FAIL reset_sout: got %b want 0", sout); end
        vectors++; if (sout_valid !== 1'b0) begin miscompares++; $display("FAIL reset_sout_valid: got %b want 0", sout_valid); end
        vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b want 0", done); end
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        int start;
        int n;
        tick();
        I = 4'b1011; load_valid = 1'b1; shift_en = 1'b1;
        push_word(4'b1011);
        start = done_cnt;
        tick();
        load_valid = 1'b0;
        @(negedge clk);
        vectors++; if (load_ready !== 1'b0) begin miscompares++; $display("FAIL basic_ready_drop: got %b want 0", load_ready); end
        vectors++; if (sout_valid !== 1'b1) begin miscompares++; $display("FAIL basic_valid: got %b want 1", sout_valid); end
        n = 0;
        while (done_cnt == start && n < 4 * c_BITS) begin
            @(negedge clk);
            n++;
        end
        vectors++; if (n !== c_BITS) begin miscompares++; $display("FAIL basic_done_latency: got %0d want %0d", n, c_BITS); end
        vectors++; if (load_ready !== 1'b1) begin miscompares++; $display("FAIL basic_ready_back: got %b want 1", load_ready); end
        vectors++; if (exp_q.size() !== 0) begin miscompares++; $display("FAIL basic_bits_left: got %0d want 0", exp_q.size()); end
        @(negedge clk);
        vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL basic_done_width: got %b want 0", done); end
    endtask

    task automatic test_toggle();
        logic [6:0] pat;
        logic       prev;
        int         start;
        int         n;
        pat = 7'b1001101;
        prev = 1'b0;
        tick();
        I = 4'b0110; load_valid = 1'b1; shift_en = 1'b0;
        push_word(4'b0110);
        start = done_cnt;
        tick();
        load_valid = 1'b0;
        for (int k = 0; k < 7; k++) begin
            shift_en = pat[6-k];
            @(negedge clk);
            vectors++; if (sout_valid !== 1'b1) begin miscompares++; $display("FAIL toggle_valid k=%0d: got %b want 1", k, sout_valid); end
            if (k > 0 && !pat[7-k]) begin
                vectors++; if (sout !== prev) begin miscompares++; $display("FAIL toggle_hold k=%0d: got %b want %b", k, sout, prev); end
            end
            prev = sout;
            tick();
        end
        shift_en = 1'b1;
        n = 0;
        while (done_cnt == start && n < 10) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        vectors++; if (done_cnt !== start + 1) begin miscompares++; $display("FAIL toggle_done_count: got %0d want %0d", done_cnt - start, 1); end
        vectors++; if (exp_q.size() !== 0) begin miscompares++; $display("FAIL toggle_bits_left: got %0d want 0", exp_q.size()); end
    endtask

    task automatic test_load_ignored();
        int start;
        tick();
        I = 4'b1000; load_valid = 1'b1; shift_en = 1'b1;
        push_word(4'b1000);
        push_word(4'b1111);
        start = done_cnt;
        tick();
        I = 4'b1111;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (done_cnt >= start + 2) break;
            if (sout_valid) begin
                vectors++; if (load_ready !== 1'b0) begin miscompares++; $display("FAIL held_ready_in_shift: got %b want 0", load_ready); end
            end
            if (load_ready && load_valid) begin
                vectors++; if (done_cnt !== start + 1) begin miscompares++; $display("FAIL held_capture_cycle: got %0d dones want 1", done_cnt - start); end
                tick();
                load_valid = 1'b0;
            end else begin
                tick();
            end
        end
        vectors++; if (done_cnt !== start + 2) begin miscompares++; $display("FAIL held_done_count: got %0d want 2", done_cnt - start); end
        vectors++; if (exp_q.size() !== 0) begin miscompares++; $display("FAIL held_bits_left: got %0d want 0", exp_q.size()); end
    endtask

    task automatic test_reset_mid();
        int start;
        int n;
        tick();
        I = 4'b1111; load_valid = 1'b1; shift_en = 1'b1;
        push_word(4'b1111);
        start = done_cnt;
        tick();
        load_valid = 1'b0;
        repeat (2) tick();
        #2 rst_n = 1'b0;
        #1;
        vectors++; if (sout_valid !== 1'b0) begin miscompares++; $display("FAIL midrst_valid: got %b want 0", sout_valid); end
        vectors++; if (sout !== 1'b0) begin miscompares++; $display("FAIL midrst_sout: got %b want 0", sout); end
        vectors++; if (load_ready !== 1'b1) begin miscompares++; $display("FAIL midrst_ready: got %b want 1", load_ready); end
        exp_q.delete();
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        vectors++; if (done_cnt !== start) begin miscompares++; $display("FAIL midrst_no_done: got %0d dones want 0", done_cnt - start); end
        tick();
        I = 4'b0101; load_valid = 1'b1;
        push_word(4'b0101);
        tick();
        load_valid = 1'b0;
        n = 0;
        while (done_cnt == start && n < 20) begin
            @(negedge clk);
            n++;
        end
        vectors++; if (done_cnt !== start + 1) begin miscompares++; $display("FAIL midrst_reload_done: got %0d want 1", done_cnt - start); end
        vectors++; if (exp_q.size() !== 0) begin miscompares++; $display("FAIL midrst_bits_left: got %0d want 0", exp_q.size()); end
    endtask

    task automatic test_back_to_back();
        int start;
        int loads;
        loads = 0;
        tick();
        I = 4'b1100; load_valid = 1'b1; shift_en = 1'b1;
        push_word(4'b1100);
        push_word(4'b0011);
        start = done_cnt;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (done_cnt >= start + 2) break;
            if (load_ready && load_valid) begin
                loads++;
                if (loads == 2) begin
                    vectors++; if (sout_valid !== 1'b0) begin miscompares++; $display("FAIL b2b_gap: got sout_valid=%b want 0", sout_valid); end
                end
                tick();
                if (loads == 1) I = 4'b0011;
                else load_valid = 1'b0;
            end else begin
                tick();
            end
        end
        vectors++; if (done_cnt !== start + 2) begin miscompares++; $display("FAIL b2b_done_count: got %0d want 2", done_cnt - start); end
        vectors++; if (last_done - prev_done !== c_BITS + 1) begin miscompares++; $display("FAIL b2b_spacing: got %0d want %0d", last_done - prev_done, c_BITS + 1); end
        vectors++; if (exp_q.size() !== 0) begin miscompares++; $display("FAIL b2b_bits_left: got %0d want 0", exp_q.size()); end
    endtask

`ifdef PISO_PARITY_EN
    task automatic test_parity();
        int start;
        int n;
        tick();
        I = 4'b1001; load_valid = 1'b1; shift_en = 1'b1;
        push_word(4'b1001);
        start = done_cnt;
        tick();
        load_valid = 1'b0;
        n = 0;
        while (done_cnt == start && n < 20) begin
            @(negedge clk);
            n++;
        end
        vectors++; if (n !== 6) begin miscompares++; $display("FAIL parity_done_latency: got %0d want 6", n); end
        vectors++; if (exp_q.size() !== 0) begin miscompares++; $display("FAIL parity_bits_left: got %0d want 0", exp_q.size()); end
    endtask
`endif

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic();
        test_toggle();
        test_load_ignored();
        test_reset_mid();
        test_back_to_back();
`ifdef PISO_PARITY_EN
        test_parity();
`endif
        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/piso_shift_tx.md
Name: piso_shift_tx

Overview:
- Parallel-in, serial-out transmitter. It is the serialising end for words held in the team's parallel-load registers.
- Accepts an N-bit word through a valid/ready load handshake, then shifts it out MSB-first, one bit per `shift_en` strobe.
- Signals completion with a one-cycle `done` pulse.
- Sits between a parallel register stage and a serial link or downstream SIPO receiver.

Parameters:
- N, 4, data word width in bits; must be ≥ 2.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- I  input  N  parallel data word to transmit.
- load_valid  input  1  upstream has a word on I.
- load_ready  output  1  block can accept a word; high only in IDLE.
- shift_en  input  1  bit strobe; advances the serial stream by one bit when high in SHIFT.
- sout  output  1  current serial bit; valid while sout_valid = 1.
- sout_valid  output  1  high in SHIFT state.
- done  output  1  registered one-cycle pulse after the last bit is consumed.

Behaviour:
- One clock, clk. Reset is asynchronous, active-low, named rst_n.
- Reset values while rst_n = 0:
  - state = IDLE, shift register sreg = 0, bit counter cnt = 0.
  - sout = 0, sout_valid = 0, done = 0.
  - load_ready = 1, because it is decoded from IDLE.
- States: IDLE, SHIFT. Two-state FSM, registered state; outputs decoded from state and sreg.
- IDLE:
  - load_ready = 1, sout_valid = 0, sout = 0.
  - On a rising edge with load_valid = 1: sreg <= I, cnt <= 0, state <= SHIFT. The word is captured on that edge.
  - shift_en is ignored in IDLE.
- SHIFT:
  - load_ready = 0, sout_valid = 1, sout = sreg[N-1] (MSB-first).
  - The first bit is visible the cycle after the load edge. Load-to-first-bit latency = 1 clock.
  - On an edge with shift_en = 1 and cnt < LAST: sreg <= sreg << 1 (LSB filled with 0), cnt <= cnt + 1.
  - On an edge with shift_en = 1 and cnt == LAST: state <= IDLE, done <= 1 for exactly one cycle.
  - shift_en = 0 holds sreg, cnt and sout unchanged, for any number of cycles.
  - load_valid is ignored in SHIFT. A word presented then is not captured and must be held until load_ready = 1.
- LAST = N-1, i.e. N bits per word, when the optional feature is disabled.
- cnt width is clog2(N+1) bits, wide enough for the optional parity bit. cnt never wraps; it resets to 0 on every load.
- Back-to-back words:
  - After the final shift edge the block is in IDLE for at least one cycle, with load_ready = 1.
  - A load on that cycle starts the next word. Minimum spacing = N+1 clocks per word when shift_en is held high.
- done is registered and cleared on the next clock. It may coincide with a new load in IDLE.
- Reset mid-operation: immediate return to IDLE. The partially sent word is discarded and no done pulse is produced.

Optional Feature:
- Macro: PISO_PARITY_EN.
- Defined:
  - On load, the block also captures par = XOR of I (even parity).
  - LAST = N. After the N data bits, one extra bit is driven with sout = par and sout_valid = 1.
  - The parity bit is consumed by one more shift_en. done follows it.
- Undefined: no parity logic; exactly N bits per word.

Test Plan:
- Reset, then I=4'b1011 with load_valid for 1 cycle, shift_en held high -> load_ready drops the next cycle; sout = 1,0,1,1 on 4 consecutive cycles; done = 1 on the cycle after the 4th bit; load_ready = 1 again.
- I=4'b0110, shift_en toggled 1,0,0,1,1,0,1 -> sout changes only after edges with shift_en = 1; sequence 0,1,1,0; sout_valid stays high throughout; exactly one done pulse.
- Load 4'b1000, then load_valid = 1 with I=4'b1111 during SHIFT -> stream is 1,0,0,0; the second word is captured only once IDLE returns and load_ready = 1.
- Load 4'b1111, after 2 bits drive rst_n = 0 asynchronously mid-cycle -> sout_valid = 0, sout = 0, load_ready = 1 immediately; no done pulse; a new load then works normally.
- Two words 4'b1100 and 4'b0011 loaded as fast as load_ready allows, shift_en held high -> serial stream 1,1,0,0,(gap),0,0,1,1; two done pulses, 5 clocks apart.
- With PISO_PARITY_EN, I=4'b1011 -> sout = 1,0,1,1,1 (parity 1); done after the 5th bit. I=4'b1001 -> 5th bit 0.
